// File: rtl/deinterleaver.sv
// -----------------------------------------------------------------------------
// deinterleaver
//
// Receive-side partner of the block interleaver. Collects a 128-bit block
// delivered as 32 interleaved nibbles, rebuilds the 16 x 8 symbol matrix and
// replays the bits serially, one per transfer, in the original order.
//
// Nibble k (0..31) carries column col = k[4:3], bit b = k[2:0]; lane i of the
// nibble lands in matrix[LANES*col + i][SYM_BITS-1-b]. Serial bit n is read
// from matrix[n / SYM_BITS][n % SYM_BITS].
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous, active-high reset
//   i_in_bits    interleaved nibble (LANES bits)
//   i_in_valid   i_in_bits valid this cycle
//   o_in_ready   block accepts a nibble when i_in_valid & o_in_ready
//   o_out_bit    deinterleaved serial bit
//   o_out_valid  o_out_bit valid
//   i_out_ready  downstream accepts; a bit transfers on o_out_valid & i_out_ready
//   o_out_first  high with bit 0 of a block
//   o_out_last   high with the final bit of a block
//
// Build option
//   DEINTERLEAVER_PINGPONG_EN  two matrix banks; loading the next block runs
//                              concurrently with unloading the current one.
//                              Undefined: one bank, strict LOAD/UNLOAD.
// -----------------------------------------------------------------------------
module deinterleaver #(
   parameter int LANES    = 4,
   parameter int SYMBOLS  = 16,
   parameter int SYM_BITS = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [LANES-1:0] i_in_bits,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_out_bit,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_out_first,
   output logic             o_out_last
);

   localparam int NIBBLES = (SYMBOLS * SYM_BITS) / LANES;
   localparam int BITS    = SYMBOLS * SYM_BITS;
   localparam int K_W     = $clog2(NIBBLES);
   localparam int N_W     = $clog2(BITS);
   localparam int B_W     = $clog2(SYM_BITS);
   localparam int R_W     = $clog2(SYMBOLS);
   localparam int C_W     = K_W - B_W;

   localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(BITS - 1);

   localparam logic [0:0] S_LOAD   = 1'b0;
   localparam logic [0:0] S_UNLOAD = 1'b1;

   logic [0:0]     r_state;
   logic [K_W-1:0] r_k;
   logic [N_W-1:0] r_n;
   logic           r_in_ready;
   logic           r_out_valid;
   logic           r_out_bit;
   logic           r_out_first;
   logic           r_out_last;

`ifdef DEINTERLEAVER_PINGPONG_EN
   logic [SYM_BITS-1:0] r_mat [2][SYMBOLS];
   logic                r_lb;      // bank currently being loaded
   logic                r_full;    // load bank holds a complete block
   logic                w_full_now;
   logic                w_full_next;
   logic                w_rd_bank;
`else
   logic [SYM_BITS-1:0] r_mat [SYMBOLS];
`endif

   logic           w_unloading;
   logic           w_acc;
   logic           w_load_done;
   logic           w_xfer;
   logic           w_last_xfer;
   logic           w_swap;
   logic [C_W-1:0] w_col;
   logic [B_W-1:0] w_b;
   logic [R_W-1:0] w_row_base;
   logic [K_W-1:0] w_k_next;
   logic [N_W-1:0] w_n_next;
   logic           w_valid_next;
   logic           w_ready_next;
   logic           w_bit_next;
   logic [0:0]     w_state_next;

   assign w_unloading = (r_state == S_UNLOAD);
   assign w_acc       = i_in_valid & r_in_ready;
   assign w_load_done = w_acc & (r_k == K_LAST);
   assign w_xfer      = w_unloading & i_out_ready;
   assign w_last_xfer = w_xfer & (r_n == N_LAST);
   assign w_col       = r_k[K_W-1:B_W];
   assign w_b         = r_k[B_W-1:0];
   assign w_row_base  = R_W'(int'(w_col) * LANES);

`ifdef DEINTERLEAVER_PINGPONG_EN
   // A finished load bank swaps in once the unload side is idle or on its final bit.
   assign w_full_now = r_full | w_load_done;
   assign w_swap     = w_full_now & (~w_unloading | w_last_xfer);
`else
   // Single bank: input is only ready while loading, so a finished block always starts unloading.
   assign w_swap     = w_load_done;
`endif

   // Next-state computation for counters, handshakes and the registered output bit.
   always_comb begin
      w_n_next     = r_n;
      w_valid_next = r_out_valid;
      if (w_swap) begin
         w_n_next     = '0;
         w_valid_next = 1'b1;
      end else if (w_last_xfer) begin
         w_n_next     = '0;
         w_valid_next = 1'b0;
      end else if (w_xfer) begin
         w_n_next     = r_n + N_W'(1);
         w_valid_next = 1'b1;
      end else begin
         w_n_next     = r_n;
         w_valid_next = r_out_valid;
      end

      if (w_acc) begin
         if (r_k == K_LAST) begin
            w_k_next = '0;
         end else begin
            w_k_next = r_k + K_W'(1);
         end
      end else begin
         w_k_next = r_k;
      end

      w_state_next = w_valid_next ? S_UNLOAD : S_LOAD;

`ifdef DEINTERLEAVER_PINGPONG_EN
      w_full_next  = w_swap ? 1'b0 : w_full_now;
      w_ready_next = ~(w_full_next & w_valid_next);
      // On a swap the bank just loaded becomes the unload bank.
      w_rd_bank    = w_swap ? r_lb : ~r_lb;
      if (w_valid_next) begin
         w_bit_next = r_mat[w_rd_bank][w_n_next[N_W-1:B_W]][w_n_next[B_W-1:0]];
      end else begin
         w_bit_next = 1'b0;
      end
`else
      w_ready_next = ~w_valid_next;
      if (w_valid_next) begin
         w_bit_next = r_mat[w_n_next[N_W-1:B_W]][w_n_next[B_W-1:0]];
      end else begin
         w_bit_next = 1'b0;
      end
`endif
   end

   // Matrix writes: lane i goes to row LANES*col+i, bit position reversed within the symbol.
   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         for (int i = 0; i < LANES; i++) begin
`ifdef DEINTERLEAVER_PINGPONG_EN
            r_mat[r_lb][w_row_base + R_W'(i)][~w_b] <= i_in_bits[i];
`else
            r_mat[w_row_base + R_W'(i)][~w_b] <= i_in_bits[i];
`endif
         end
      end
   end

   // Control registers and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_LOAD;
         r_k         <= '0;
         r_n         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef DEINTERLEAVER_PINGPONG_EN
         r_lb        <= 1'b0;
         r_full      <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_k         <= w_k_next;
         r_n         <= w_n_next;
         r_in_ready  <= w_ready_next;
         r_out_valid <= w_valid_next;
         r_out_bit   <= w_bit_next;
         r_out_first <= w_valid_next & (w_n_next == '0);
         r_out_last  <= w_valid_next & (w_n_next == N_LAST);
`ifdef DEINTERLEAVER_PINGPONG_EN
         r_lb        <= w_swap ? ~r_lb : r_lb;
         r_full      <= w_full_next;
`endif
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_bit   = r_out_bit;
   assign o_out_first = r_out_first;
   assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_deinterleaver.sv
// -----------------------------------------------------------------------------
// tb_deinterleaver
//
// Directed bench for deinterleaver. A small interleaver model turns a 128-bit
// serial block d (serial bit j = d[j]) into 32 nibbles; the deinterleaver must
// return the same serial bits. Table vectors cover the main function,
// backpressure and input gaps; hand-written sequences cover mid-block resets
// and, when DEINTERLEAVER_PINGPONG_EN is defined, back-to-back blocks.
// -----------------------------------------------------------------------------
module tb_deinterleaver;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic [3:0] in_bits   = 4'h0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b0;
   logic       o_in_ready;
   logic       o_out_bit;
   logic       o_out_valid;
   logic       o_out_first;
   logic       o_out_last;

   int total = 0;
   int bad   = 0;

`ifdef DEINTERLEAVER_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   deinterleaver dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_bits   (in_bits),
      .i_in_valid  (in_valid),
      .o_in_ready  (o_in_ready),
      .o_out_bit   (o_out_bit),
      .o_out_valid (o_out_valid),
      .i_out_ready (out_ready),
      .o_out_first (o_out_first),
      .o_out_last  (o_out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] d;      // serial block fed to the interleaver model
      logic [127:0] exp;    // expected serial output
      bit           bp;     // out_ready pattern 1,0,0,1
      bit           gaps;   // random in_valid gaps and junk during unload
   } vec_t;

   vec_t vt [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Interleaver model: matrix[s][j] = d[8s+j]; nibble k lane i = matrix[4*col+i][7-b].
   function automatic logic [3:0] nib(input logic [127:0] d, input int k);
      logic [3:0] r;
      int col;
      int b;
      col = k / 8;
      b   = k % 8;
      for (int i = 0; i < 4; i++) r[i] = d[8 * (4 * col + i) + 7 - b];
      return r;
   endfunction

   // Send nibbles 0..nlim-1 of block d; entered and left at posedge+1.
   task automatic send_block(input logic [127:0] d, input int nlim, input bit gaps);
      int t;
      for (int k = 0; k < nlim; k++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_bits  = 4'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_bits  = nib(d, k);
         t = 0;
         @(negedge clk);
         while (!o_in_ready && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (!o_in_ready) chk("in_ready_wait", {31'd0, o_in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Receive nmax bits and compare them; entered and left at posedge+1.
   task automatic recv(input logic [127:0] exp, input bit bp, input bit junk, input int nmax);
      int   n;
      int   cyc;
      bit   st;
      logic pb, pf, pl;
      n = 0; cyc = 0; st = 1'b0; pb = 1'b0; pf = 1'b0; pl = 1'b0;
      while (n < nmax && cyc < 2000) begin
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (junk) begin
            in_valid = 1'b1;
            in_bits  = 4'($urandom);
         end
         @(negedge clk);
         if (st) begin
            chk("stall_valid", {31'd0, o_out_valid}, 32'd1);
            chk("stall_bit",   {31'd0, o_out_bit},   {31'd0, pb});
            chk("stall_first", {31'd0, o_out_first}, {31'd0, pf});
            chk("stall_last",  {31'd0, o_out_last},  {31'd0, pl});
         end
         if (!PP) chk("in_ready_unload", {31'd0, o_in_ready}, 32'd0);
         if (o_out_valid && out_ready) begin
            chk($sformatf("bit%0d", n), {31'd0, o_out_bit},   {31'd0, exp[n]});
            chk("out_first",            {31'd0, o_out_first}, {31'd0, (n == 0)});
            chk("out_last",             {31'd0, o_out_last},  {31'd0, (n == 127)});
            n++;
            st = 1'b0;
         end else begin
            st = o_out_valid;
            pb = o_out_bit;
            pf = o_out_first;
            pl = o_out_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("recv_count", n, nmax);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Full block: load, first-bit latency, unload, return to idle.
   task automatic run_block(input logic [127:0] d, input logic [127:0] exp, input bit bp, input bit gaps);
      send_block(d, 32, gaps);
      @(negedge clk);
      chk("lat_valid", {31'd0, o_out_valid}, 32'd1);
      chk("lat_first", {31'd0, o_out_first}, 32'd1);
      chk("lat_last",  {31'd0, o_out_last},  32'd0);
      if (!PP) chk("lat_in_ready", {31'd0, o_in_ready}, 32'd0);
      @(posedge clk); #1;
      recv(exp, bp, gaps && !PP, 128);
      @(negedge clk);
      chk("end_valid",    {31'd0, o_out_valid}, 32'd0);
      chk("end_in_ready", {31'd0, o_in_ready},  32'd1);
      chk("end_first",    {31'd0, o_out_first}, 32'd0);
      chk("end_last",     {31'd0, o_out_last},  32'd0);
      @(posedge clk); #1;
   endtask

   // Pulse reset away from the clock edge and check the outputs clear at once.
   task automatic mid_reset(input string nm);
      rst = 1'b1;
      #1;
      chk({nm, "_in_ready"}, {31'd0, o_in_ready},  32'd1);
      chk({nm, "_valid"},    {31'd0, o_out_valid}, 32'd0);
      chk({nm, "_first"},    {31'd0, o_out_first}, 32'd0);
      chk({nm, "_last"},     {31'd0, o_out_last},  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{128'h0000_0000_0000_0000_0000_0000_0000_00FF,
                128'h0000_0000_0000_0000_0000_0000_0000_00FF, 1'b0, 1'b0};
      vt[1] = '{128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 1'b0, 1'b0};
      vt[2] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b0};
      vt[3] = '{128'hA5C3_1E7B_DEAD_BEEF_5A3C_E187_0F96_C0DE,
                128'hA5C3_1E7B_DEAD_BEEF_5A3C_E187_0F96_C0DE, 1'b0, 1'b1};

      // Reset state.
      @(negedge clk);
      chk("rst_in_ready", {31'd0, o_in_ready},  32'd1);
      chk("rst_valid",    {31'd0, o_out_valid}, 32'd0);
      chk("rst_bit",      {31'd0, o_out_bit},   32'd0);
      chk("rst_first",    {31'd0, o_out_first}, 32'd0);
      chk("rst_last",     {31'd0, o_out_last},  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 4; v++) run_block(vt[v].d, vt[v].exp, vt[v].bp, vt[v].gaps);

      // Reset after nibble 12: the partial block is dropped.
      send_block(vt[1].d, 13, 1'b0);
      mid_reset("rst_load");
      run_block(vt[2].d, vt[2].exp, 1'b0, 1'b0);

      // Reset after output bit 50.
      send_block(vt[0].d, 32, 1'b0);
      @(negedge clk);
      chk("lat2_valid", {31'd0, o_out_valid}, 32'd1);
      @(posedge clk); #1;
      recv(vt[0].exp, 1'b0, 1'b0, 51);
      mid_reset("rst_unload");
      run_block(vt[3].d, vt[3].exp, 1'b1, 1'b0);

`ifdef DEINTERLEAVER_PINGPONG_EN
      // Three back-to-back blocks: continuous 384-bit output.
      out_ready = 1'b1;
      fork
         begin
            send_block(vt[1].d, 32, 1'b0);
            send_block(vt[2].d, 32, 1'b0);
            send_block(vt[3].d, 32, 1'b0);
         end
         begin
            int t;
            logic [127:0] e;
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!o_out_valid && t < 200);
            chk("pp_latency", t, 33);
            for (int j = 0; j < 384; j++) begin
               if (j > 0) @(negedge clk);
               e = vt[1 + j / 128].exp;
               chk("pp_valid", {31'd0, o_out_valid}, 32'd1);
               chk($sformatf("pp_bit%0d", j), {31'd0, o_out_bit}, {31'd0, e[j % 128]});
               chk("pp_first", {31'd0, o_out_first}, {31'd0, (j % 128 == 0)});
               chk("pp_last",  {31'd0, o_out_last},  {31'd0, (j % 128 == 127)});
            end
            @(negedge clk);
            chk("pp_end_valid", {31'd0, o_out_valid}, 32'd0);
         end
      join
      out_ready = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/deinterleaver.md
Name: deinterleaver

Overview:
- Receive-side block matching the transmit interleaver.
- Accepts the 4-bit interleaved nibble stream: 32 nibbles per 128-bit block, 16 symbols x 8 bits.
- Reassembles the 16x8 matrix and replays the original serial bit order, 1 bit/cycle, to the downstream decoder.
- Sits between the channel demapper and the decoder.

Parameters:
- LANES, 4, nibble width; equals the number of symbols per interleave column.
- SYMBOLS, 16, symbols per block; must be a multiple of LANES.
- SYM_BITS, 8, bits per symbol; power of two.
- Only the defaults are required to be verified; the other derived widths use $clog2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_bits  input  LANES  interleaved nibble
- in_valid  input  1  in_bits is valid this cycle
- in_ready  output  1  block can accept a nibble; a nibble is accepted when in_valid & in_ready
- out_bit  output  1  deinterleaved serial bit
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream accepts out_bit; a bit transfers when out_valid & out_ready
- out_first  output  1  high with bit 0 of a block
- out_last  output  1  high with bit 127 of a block

Behaviour:
- Reset (async assert, sync release): state=LOAD, counters=0, in_ready=1, out_valid=0, out_bit=0, out_first=0, out_last=0. Matrix contents are not reset.
- Single clock, all outputs registered. Reset mid-block discards the partial block; no output is produced for it.
- LOAD, nibble counter k=0..31:
  - On acceptance, col=k[4:3], b=k[2:0], and in_bits[i] is written to matrix[4*col+i][7-b] for i=0..3.
  - When k==31 is accepted, k wraps to 0, state goes to UNLOAD and in_ready drops at the same edge.
  - in_valid while in_ready=0 is ignored; the upstream holds data.
- UNLOAD, bit counter n=0..127:
  - out_bit = matrix[n[6:3]][n[2:0]].
  - out_valid rises on the first edge after the 32nd nibble is accepted, which is a latency of 1 cycle.
  - n advances only on transfer. While out_ready=0, out_bit, out_first and out_last hold stable and out_valid stays 1.
  - out_first is high while n==0; out_last is high while n==127.
  - On the transfer of n==127: out_valid drops at that edge, n wraps to 0, state goes to LOAD and in_ready goes to 1 on the same edge.
- Round-trip guarantee: serial bit j into the interleaver equals serial bit j out of this block.
- Throughput without the optional feature: 32 load cycles + 128 unload cycles per block minimum.

Optional Feature:
- Macro DEINTERLEAVER_PINGPONG_EN.
- Defined:
  - Two matrix banks. LOAD and UNLOAD run concurrently on opposite banks.
  - in_ready = 1 unless the load bank is full and the unload bank is still draining.
  - Bank swap happens on the edge where both of these hold: the load bank is full, and the unload bank is empty or its last bit is transferring.
  - If n==127 transfers in the same cycle as nibble 31 is accepted, the next block's bit 0 is presented next cycle with no out_valid gap.
  - Sustained throughput is 1 bit/cycle.
- Undefined: single bank, strictly alternating LOAD/UNLOAD as described above.

Test Plan:
- Single symbol, out_ready=1: symbol0=0xFF, others 0x00, so nibbles 0-7=0x1 and 8-31=0x0. Response: out_valid 1 cycle after nibble 31; bits 0-7=1, bits 8-127=0; out_first on bit 0, out_last on bit 127.
- Walking pattern: symbol s=s (0x00..0x0F) sent through the interleaver model, then into the DUT. Response: output bytes 0x00..0x0F in order, MSB-first index matching the model; in_ready=0 for all 128 unload cycles.
- Backpressure: toggle out_ready 1,0,0,1 repeating during UNLOAD. Response: out_bit stable while stalled; exactly 128 transfers; in_ready returns on the final transfer edge.
- Input gaps: in_valid=0 on random cycles, and in_valid=1 while in_ready=0 during UNLOAD. Response: gap nibbles are not written; data sent during UNLOAD is ignored; the block output is unchanged.
- Reset mid-operation: assert rst after nibble 12, then again after output bit 50. Response: immediately in_ready=1, out_valid=0, out_first=0, out_last=0; the next full block is output correctly.
- DEINTERLEAVER_PINGPONG_EN: 3 back-to-back blocks with in_valid=1 and out_ready=1. Response: after the first 33 cycles, out_valid is continuously 1 for 384 cycles, and all three blocks are correct.
